// File: rtl/ahb_wait_sram_slave.sv
// AHB-Lite SRAM slave: 63 RAM words plus a read-only ID word at address 0,
// with a fixed number of wait states per OKAY transfer and a two-cycle ERROR response.
module ahb_wait_sram_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  // state   | meaning
  // ST_IDLE | ready; final data-phase cycle of an OKAY transfer when dphase is set
  // ST_WAIT | OKAY wait cycles, counter running down
  // ST_ERR1 | first ERROR cycle, HREADYOUT low
  // ST_ERR2 | second ERROR cycle, next address phase may be accepted
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [7:0]  addr_q;
  logic        write_q;
  logic [2:0]  size_q;
  logic        dphase;
  logic [31:0] mem [1:63];

  logic        accept;
  logic        req_err;
  logic        commit;
  logic [3:0]  lane_en;
  logic [31:0] rd_word;

  wire unused = &{1'b0, HADDR[31:8], HTRANS[0], HBURST};

  assign accept  = HSEL && HREADY && HTRANS[1];
  assign req_err = (HSIZE > 3'b010)
                || ((HSIZE == 3'b001) && HADDR[0])
                || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
                || (HWRITE && (HADDR[7:2] == 6'd0));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      addr_q  <= 8'd0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      dphase  <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= ST_IDLE;
        end
        ST_ERR1: state <= ST_ERR2;
        default: begin
          // ST_IDLE and ST_ERR2 both take a new address phase
          dphase <= 1'b0;
          state  <= ST_IDLE;
          if (accept) begin
            addr_q  <= HADDR[7:0];
            write_q <= HWRITE;
            size_q  <= HSIZE;
            if (req_err) begin
              state <= ST_ERR1;
            end else begin
              dphase <= 1'b1;
              if (WAIT_STATES > 0) begin
                state <= ST_WAIT;
                cnt   <= 3'(WAIT_STATES);
              end
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      3'b000:  lane_en[addr_q[1:0]] = 1'b1;
      3'b001:  lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Only legal OKAY writes reach commit, so word 0 is never written
  assign commit = !HRESET && (state == ST_IDLE) && dphase && write_q;

  always_ff @(posedge HCLK) begin
    if (commit) begin
      if (lane_en[0]) mem[addr_q[7:2]][7:0]   <= HWDATA[7:0];
      if (lane_en[1]) mem[addr_q[7:2]][15:8]  <= HWDATA[15:8];
      if (lane_en[2]) mem[addr_q[7:2]][23:16] <= HWDATA[23:16];
      if (lane_en[3]) mem[addr_q[7:2]][31:24] <= HWDATA[31:24];
    end
  end

  assign rd_word   = (addr_q[7:2] == 6'd0) ? ID_VALUE : mem[addr_q[7:2]];
  assign HRDATA    = ((state == ST_IDLE) && dphase && !write_q) ? rd_word : 32'h0;
  assign HREADYOUT = (state == ST_IDLE) || (state == ST_ERR2);
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);

endmodule

// File: tb/tb_ahb_wait_sram_slave.sv
// Randomized bench for ahb_wait_sram_slave: two instances (1 and 0 wait states)
// checked cycle by cycle against a transfer-level model of the slave.
module tb_ahb_wait_sram_slave;

  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  bit          tgt;

  logic        rdy_a, resp_a, rdy_b, resp_b;
  logic [31:0] rd_a, rd_b;
  logic        hsel_a, hsel_b, rdy_m, resp_m;
  logic [31:0] rd_m;

  assign hsel_a = hsel && !tgt;
  assign hsel_b = hsel && tgt;
  assign rdy_m  = tgt ? rdy_b  : rdy_a;
  assign resp_m = tgt ? resp_b : resp_a;
  assign rd_m   = tgt ? rd_b   : rd_a;

  always #5 clk = ~clk;

  ahb_wait_sram_slave #(.WAIT_STATES(1)) u_w1 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy_a), .HREADYOUT(rdy_a), .HRESP(resp_a), .HRDATA(rd_a)
  );

  ahb_wait_sram_slave #(.WAIT_STATES(0)) u_w0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy_b), .HREADYOUT(rdy_b), .HRESP(resp_b), .HRDATA(rd_b)
  );

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [7:0]  addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  // Expected data-phase cycles of accepted transfers
  typedef enum int {K_WAIT, K_ERR1, K_ERR2, K_FINAL} kind_t;
  typedef struct {
    kind_t       kind;
    bit          write;
    logic [7:0]  addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } ph_t;

  op_t         ops[$];
  ph_t         q[$];
  logic [31:0] mm [2][64];
  logic [31:0] last_rd;
  int          checks = 0;
  int          fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic op_t mk(bit w, logic [7:0] a, logic [2:0] s, logic [31:0] d,
                             logic [1:0] t = 2'b10);
    op_t o;
    o.sel = 1'b1; o.trans = t; o.write = w; o.addr = a; o.size = s; o.wdata = d;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int  r;
    o.sel   = ($urandom_range(0, 9) != 0);
    r       = $urandom_range(0, 9);
    o.trans = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
    o.write = 1'($urandom_range(0, 1));
    o.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    o.addr  = 8'($urandom);
    if ($urandom_range(0, 3) != 0) begin
      if (o.size == 3'd1) o.addr[0] = 1'b0;
      if (o.size == 3'd2) o.addr[1:0] = 2'b00;
    end
    o.wdata = $urandom;
    return o;
  endfunction

  function automatic logic [31:0] model_read(logic [7:0] a);
    return (a[7:2] == 6'd0) ? ID : mm[tgt][a[7:2]];
  endfunction

  function automatic void model_write(ph_t f);
    logic [31:0] w = mm[tgt][f.addr[7:2]];
    for (int b = 0; b < 4; b++) begin
      bit en = (f.size == 3'd2) ||
               (f.size == 3'd1 && (b / 2) == int'(f.addr[1])) ||
               (f.size == 3'd0 && b == int'(f.addr[1:0]));
      if (en) w[8*b +: 8] = f.wdata[8*b +: 8];
    end
    mm[tgt][f.addr[7:2]] = w;
  endfunction

  task automatic push_transfer(op_t o);
    ph_t p;
    bit  err;
    int  waits = tgt ? 0 : 1;
    err = (o.size > 3'd2) || (o.size == 3'd1 && o.addr[0]) ||
          (o.size == 3'd2 && o.addr[1:0] != 2'b00) || (o.write && o.addr[7:2] == 6'd0);
    p.write = o.write; p.addr = o.addr; p.size = o.size; p.wdata = o.wdata;
    if (err) begin
      p.kind = K_ERR1; q.push_back(p);
      p.kind = K_ERR2; q.push_back(p);
    end else begin
      p.kind = K_WAIT;
      for (int i = 0; i < waits; i++) q.push_back(p);
      p.kind = K_FINAL; q.push_back(p);
    end
  endtask

  task automatic do_cycle();
    ph_t         f;
    op_t         o;
    bit          have, acc;
    logic        e_rdy, e_resp;
    logic [31:0] e_rd;
    @(negedge clk);
    have = (q.size() != 0);
    e_rdy = 1'b1; e_resp = 1'b0; e_rd = 32'h0;
    if (have) begin
      f = q[0];
      case (f.kind)
        K_WAIT:  e_rdy = 1'b0;
        K_ERR1:  begin e_rdy = 1'b0; e_resp = 1'b1; end
        K_ERR2:  e_resp = 1'b1;
        default: if (!f.write) e_rd = model_read(f.addr);
      endcase
      if (f.kind == K_FINAL && !f.write) last_rd = rd_m;
    end
    chk("hreadyout", 32'(rdy_m), 32'(e_rdy));
    chk("hresp", 32'(resp_m), 32'(e_resp));
    chk("hrdata", rd_m, e_rd);
    hwdata = (have && f.write) ? f.wdata : $urandom;
    acc = 1'b0;
    if (e_rdy) begin
      if (ops.size() != 0) begin
        o      = ops.pop_front();
        hsel   = o.sel;
        htrans = o.trans;
        haddr  = {24'($urandom), o.addr};
        hwrite = o.write;
        hsize  = o.size;
        hburst = 3'($urandom);
        acc    = o.sel && o.trans[1];
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
    end
    @(posedge clk);
    if (have) begin
      void'(q.pop_front());
      if (f.kind == K_FINAL && f.write) model_write(f);
    end
    if (acc) push_transfer(o);
  endtask

  task automatic run_ops(input int budget);
    int n = 0;
    while ((ops.size() != 0 || q.size() != 0) && n < budget) begin
      do_cycle();
      n++;
    end
    chk("drain", 32'(ops.size() + q.size()), 32'd0);
    ops.delete();
    q.delete();
  endtask

  task automatic fill_mem();
    for (int w = 1; w < 64; w++) ops.push_back(mk(1'b1, 8'(w * 4), 3'd2, $urandom));
    run_ops(400);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hwdata = '0; tgt = 1'b0; last_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy_w1", 32'(rdy_a), 32'd1);
    chk("rst_resp_w1", 32'(resp_a), 32'd0);
    chk("rst_rd_w1", rd_a, 32'h0);
    chk("rst_rdy_w0", 32'(rdy_b), 32'd1);
    chk("rst_resp_w0", 32'(resp_b), 32'd0);
    chk("rst_rd_w0", rd_b, 32'h0);
    rst = 1'b0;

    // one wait state instance
    tgt = 1'b0;
    fill_mem();
    ops.push_back(mk(1'b1, 8'h10, 3'd2, 32'hDEADBEEF));
    ops.push_back(mk(1'b0, 8'h10, 3'd2, 32'h0));
    run_ops(50);
    chk("word_rd_0x10", last_rd, 32'hDEADBEEF);
    ops.push_back(mk(1'b1, 8'h13, 3'd0, 32'h5500_0000));
    ops.push_back(mk(1'b0, 8'h10, 3'd2, 32'h0));
    run_ops(50);
    chk("byte_merge_0x10", last_rd, 32'h55ADBEEF);
    ops.push_back(mk(1'b0, 8'h02, 3'd2, 32'h0));
    ops.push_back(mk(1'b0, 8'h10, 3'd2, 32'h0));
    run_ops(50);
    chk("rd_after_err", last_rd, 32'h55ADBEEF);
    ops.push_back(mk(1'b1, 8'h00, 3'd2, 32'h12345678));
    ops.push_back(mk(1'b0, 8'h00, 3'd2, 32'h0));
    run_ops(50);
    chk("id_word", last_rd, ID);

    // reset during the wait state of a pending write
    ops.push_back(mk(1'b1, 8'h40, 3'd2, 32'hCAFEF00D));
    do_cycle();
    @(negedge clk);
    rst = 1'b1; hsel = 1'b0; htrans = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midwait_rst_rdy", 32'(rdy_a), 32'd1);
    chk("midwait_rst_resp", 32'(resp_a), 32'd0);
    chk("midwait_rst_rd", rd_a, 32'h0);
    rst = 1'b0;
    q.delete();
    ops.push_back(mk(1'b0, 8'h40, 3'd2, 32'h0));
    run_ops(50);
    chk("aborted_write", last_rd, mm[0][16]);

    for (int i = 0; i < 300; i++) ops.push_back(rnd_op());
    run_ops(2000);

    // zero wait state instance
    tgt = 1'b1;
    fill_mem();
    ops.push_back(mk(1'b1, 8'h20, 3'd2, 32'h1234ABCD, 2'b10));
    ops.push_back(mk(1'b1, 8'h24, 3'd2, 32'h0F0F0F0F, 2'b11));
    ops.push_back(mk(1'b0, 8'h20, 3'd2, 32'h0, 2'b10));
    run_ops(20);
    chk("b2b_rd_0x20", last_rd, 32'h1234ABCD);
    for (int i = 0; i < 300; i++) ops.push_back(rnd_op());
    run_ops(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ahb_wait_sram_slave.md
AHB_WAIT_SRAM_SLAVE -- requirements
Module: ahb_wait_sram_slave

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, range 0..7: wait cycles inserted in every OKAY data phase.
REQ-002 SHALL have parameter ID_VALUE, default 32'hA5B0_0001: read-only contents of word 0.
REQ-003 SHALL have port HCLK, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port HRESET, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port HSEL, input, 1: slave select from the address decoder.
REQ-006 SHALL have port HADDR, input, 32: address; only HADDR[7:0] used, giving a 64-word window.
REQ-007 SHALL have port HTRANS, input, 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 SHALL have port HWRITE, input, 1: 1=write, 0=read.
REQ-009 SHALL have port HSIZE, input, 3: transfer size; 000=byte, 001=half, 010=word.
REQ-010 SHALL have port HBURST, input, 3: burst type; accepted and ignored.
REQ-011 SHALL have port HWDATA, input, 32: write data, sampled in the data phase.
REQ-012 SHALL have port HREADY, input, 1: bus-level ready returned from the slave mux.
REQ-013 SHALL have port HREADYOUT, output, 1: this slave's ready.
REQ-014 SHALL have port HRESP, output, 1: 0=OKAY, 1=ERROR.
REQ-015 SHALL have port HRDATA, output, 32: read data.

Function
REQ-016 SHALL accept an address phase on a rising edge only when HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ or SEQ; SEQ is handled identically).
REQ-017 SHALL register the accepted address, HWRITE and HSIZE, and SHALL leave them unchanged until the data phase completes.
REQ-018 SHALL treat IDLE, BUSY or HSEL=0 with HREADY=1 as no transfer: the next cycle is a zero-wait OKAY with HREADYOUT=1 and HRESP=0.
REQ-019 SHALL flag an error on an accepted transfer when any of these holds: HSIZE>010; HSIZE=001 with HADDR[0]=1; HSIZE=010 with HADDR[1:0]!=00; write to word 0.
REQ-020 SHALL use FSM states ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2; all outputs SHALL be driven from registers or from state decode only.
REQ-021 ST_IDLE: HREADYOUT=1, HRESP=0; on accept, go to ST_ERR1 if errored, ST_WAIT with counter=WAIT_STATES if WAIT_STATES>0, else complete the data phase this cycle.
REQ-022 ST_WAIT: HREADYOUT=0, HRESP=0; counter decrements each cycle; when the counter reaches 1, the next cycle is the final data-phase cycle, in state ST_IDLE with HREADYOUT=1.
REQ-023 ST_ERR1: HREADYOUT=0, HRESP=1, for exactly one cycle, then ST_ERR2.
REQ-024 ST_ERR2: HREADYOUT=1, HRESP=1, for exactly one cycle; an address phase presented in this cycle SHALL be accepted per REQ-016.
REQ-025 SHALL perform an errored transfer with no memory write and HRDATA=0.
REQ-026 Write: SHALL update memory at the edge ending the final data-phase cycle using HWDATA, with byte lanes enabled per HSIZE and HADDR[1:0] (little-endian); other lanes SHALL be unchanged.
REQ-027 Read: HRDATA SHALL equal the full addressed word during the final data-phase cycle, with word 0 returning ID_VALUE; HRDATA SHALL be 0 in all other cycles.
REQ-028 Back-to-back: a new address phase may be accepted in the same cycle a data phase completes, giving zero idle cycles.
REQ-029 A read immediately following a write to the same word SHALL return the newly written data, with no bypass logic required since the write commits before the read data phase.
REQ-030 Memory SHALL be 63 words (words 1..63) of inferred registers; memory contents SHALL NOT be cleared by reset.

Reset
REQ-031 While HRESET=1 at an edge: state=ST_IDLE, counter=0, registered controls cleared, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-032 Reset asserted mid-wait or mid-error SHALL abort the transfer, and any pending write SHALL be discarded.
REQ-033 HRESET SHALL take priority over all other inputs.

Verification
REQ-034 Reset: HRESET=1 for 2 cycles during ST_WAIT -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0, and the pending word is unchanged.
REQ-035 WAIT_STATES=1: word write 32'hDEADBEEF to 0x10, then word read of 0x10 -> each data phase has HREADYOUT=0 for 1 cycle then 1; read HRDATA=32'hDEADBEEF.
REQ-036 Byte write 8'h55 to 0x13 over 32'hDEADBEEF, with HWDATA=32'h5500_0000 -> word read of 0x10 returns 32'h55ADBEEF.
REQ-037 Word read of 0x02 (misaligned) -> one cycle HREADYOUT=0/HRESP=1, then one cycle HREADYOUT=1/HRESP=1, HRDATA=0; the following NONSEQ is accepted in the ST_ERR2 cycle.
REQ-038 Word write 32'h12345678 to 0x00 -> two-cycle ERROR; subsequent read of 0x00 returns 32'hA5B0_0001.
REQ-039 WAIT_STATES=0: NONSEQ write 0x20, SEQ write 0x24, NONSEQ read 0x20 back-to-back -> HREADYOUT stays 1 throughout; read returns the first write data.
